// File: rtl/branch_pkg.sv
// Shared types and branch-condition helper for the branch resolution slice.
package branch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned PHT_IDX_W = 3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                 pred_taken;
        logic [PHT_IDX_W-1:0] pht_index;
        logic [XLEN-1:0]      pc;
    } pred_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    // Real branch direction; reserved encodings 010/011 resolve not-taken.
    function automatic logic branch_taken(input logic [2:0]      funct3,
                                          input logic [XLEN-1:0] rs1,
                                          input logic [XLEN-1:0] rs2);
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-flight prediction FIFO: sync, power-of-two depth, clear wins over push/pop.
module pred_fifo
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  pred_entry_t wdata_i,
    output pred_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pred_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_q;
    assign do_push = push_i & (~full_q | do_pop);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: EX compare, MEM-stage outcome registers, mispredict flush FSM.
// Optional saturating branch/mispredict counters built when BRANCH_STATS_EN is defined.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        id_enq,
    input  logic        id_pred_taken,
    input  logic [2:0]  id_pht_index,
    input  logic [31:0] id_pc,
    output logic        fifo_full,
    input  logic        ex_valid,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [31:0] ex_target,
    output logic        branch_resolved,
    output logic        actual_taken,
    output logic [2:0]  pht_index_mem,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        protocol_err,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    pred_entry_t       enq_entry;
    pred_entry_t       fifo_head;
    pred_entry_t       head_c;
    logic              fifo_empty;
    logic              fifo_full_w;
    logic              resolve_c;
    logic              taken_c;
    logic              mispred_c;
    logic [31:0]       redirect_c;

    flush_state_e      state_q;
    flush_state_e      state_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;

    logic              resolved_q;
    logic              taken_q;
    logic [2:0]        idx_q;
    logic              mispred_q;
    logic [31:0]       redirect_q;
    logic              proto_err_q;

    assign enq_entry = {id_pred_taken, id_pht_index, id_pc};

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (mispred_q),
        .push_i  (id_enq & ~stall & ~flush),
        .pop_i   (ex_valid & ~stall),
        .wdata_i (enq_entry),
        .rdata_o (fifo_head),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty)
    );

    // An orphan EX branch resolves against an all-zero entry (pred not-taken, idx 0, pc 0).
    assign head_c     = fifo_empty ? pred_entry_t'('0) : fifo_head;
    assign resolve_c  = ex_valid & ~stall;
    assign taken_c    = branch_taken(ex_funct3, ex_rs1, ex_rs2);
    assign mispred_c  = taken_c ^ head_c.pred_taken;
    assign redirect_c = taken_c ? ex_target : head_c.pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            idx_q      <= '0;
            mispred_q  <= 1'b0;
            redirect_q <= '0;
        end else if (!stall) begin
            resolved_q <= ex_valid;
            mispred_q  <= ex_valid & mispred_c;
            if (ex_valid) begin
                taken_q    <= taken_c;
                idx_q      <= head_c.pht_index;
                redirect_q <= redirect_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (resolve_c && fifo_empty) begin
            proto_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Enter (or restart) flush on the cycle the mispredict is registered.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (resolve_c && mispred_c) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
        end else if (state_q == ST_FLUSH && !stall) begin
            if (fcnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                fcnt_d = fcnt_q - FCNT_W'(1);
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (resolve_c) begin
            if (stat_br_q != 32'hFFFF_FFFF)           stat_br_q <= stat_br_q + 32'd1;
            if (mispred_c && stat_mp_q != 32'hFFFF_FFFF) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

    assign fifo_full       = fifo_full_w;
    assign branch_resolved = resolved_q;
    assign actual_taken    = taken_q;
    assign pht_index_mem   = idx_q;
    assign mispredict      = mispred_q;
    assign redirect_pc     = redirect_q;
    assign flush           = (state_q == ST_FLUSH);
    assign protocol_err    = proto_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus corner-case sequences.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_enq;
    logic        id_pred_taken;
    logic [2:0]  id_pht_index;
    logic [31:0] id_pc;
    logic        fifo_full;
    logic        ex_valid;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_target;
    logic        branch_resolved;
    logic        actual_taken;
    logic [2:0]  pht_index_mem;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        protocol_err;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .id_enq           (id_enq),
        .id_pred_taken    (id_pred_taken),
        .id_pht_index     (id_pht_index),
        .id_pc            (id_pc),
        .fifo_full        (fifo_full),
        .ex_valid         (ex_valid),
        .ex_funct3        (ex_funct3),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_target        (ex_target),
        .branch_resolved  (branch_resolved),
        .actual_taken     (actual_taken),
        .pht_index_mem    (pht_index_mem),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .protocol_err     (protocol_err),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        logic        pt;
        logic [2:0]  idx;
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] tgt;
        logic        e_taken;
        logic        e_mp;
        logic [31:0] e_redir;
    } vec_t;

    typedef struct packed {
        logic        taken;
        logic        mp;
        logic [2:0]  idx;
        logic [31:0] redir;
    } exp_t;

    vec_t  vecs [10];
    exp_t  sb [$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    n_br   = 0;
    int    n_mp   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one cycle; any outcome promised last cycle must appear now.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resolved",    32'(branch_resolved), 32'd1);
            chk("taken",       32'(actual_taken),    32'(e.taken));
            chk("mispredict",  32'(mispredict),      32'(e.mp));
            chk("pht_index",   32'(pht_index_mem),   32'(e.idx));
            chk("redirect_pc", redirect_pc,          e.redir);
        end
    endtask

    task automatic drive_enq(input logic pt, input logic [2:0] idx, input logic [31:0] pc);
        id_enq        = 1'b1;
        id_pred_taken = pt;
        id_pht_index  = idx;
        id_pc         = pc;
        step();
        id_enq = 1'b0;
    endtask

    task automatic set_ex(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] tgt, input logic e_taken, input logic e_mp,
                          input logic [2:0] e_idx, input logic [31:0] e_redir);
        exp_t e;
        ex_valid  = 1'b1;
        ex_funct3 = f3;
        ex_rs1    = a;
        ex_rs2    = b;
        ex_target = tgt;
        e.taken = e_taken;
        e.mp    = e_mp;
        e.idx   = e_idx;
        e.redir = e_redir;
        sb.push_back(e);
        n_br++;
        if (e_mp) n_mp++;
    endtask

    task automatic drive_ex(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] tgt, input logic e_taken, input logic e_mp,
                            input logic [2:0] e_idx, input logic [31:0] e_redir);
        set_ex(f3, a, b, tgt, e_taken, e_mp, e_idx, e_redir);
        step();
        ex_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd5, 32'h0000_0100, F3_BEQ,  32'd7,         32'd7,         32'h0000_0180, 1'b1, 1'b0, 32'h0000_0180};
        vecs[1] = '{1'b1, 3'd2, 32'h0000_0200, F3_BNE,  32'd5,         32'd5,         32'h0000_0280, 1'b0, 1'b1, 32'h0000_0204};
        vecs[2] = '{1'b0, 3'd1, 32'h0000_0300, F3_BLT,  32'hFFFF_FFFF, 32'd1,         32'h0000_0340, 1'b1, 1'b1, 32'h0000_0340};
        vecs[3] = '{1'b0, 3'd3, 32'h0000_0400, F3_BLTU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0440, 1'b0, 1'b0, 32'h0000_0404};
        vecs[4] = '{1'b0, 3'd4, 32'h0000_0500, 3'b010,  32'd3,         32'd3,         32'h0000_0540, 1'b0, 1'b0, 32'h0000_0504};
        vecs[5] = '{1'b1, 3'd6, 32'h0000_0600, F3_BGE,  32'd1,         32'hFFFF_FFFF, 32'h0000_0700, 1'b1, 1'b0, 32'h0000_0700};
        vecs[6] = '{1'b1, 3'd7, 32'hFFFF_FFFC, F3_BGEU, 32'd1,         32'hFFFF_FFFF, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0000};
        vecs[7] = '{1'b0, 3'd0, 32'h0000_0800, F3_BNE,  32'd1,         32'd2,         32'h0000_0900, 1'b1, 1'b1, 32'h0000_0900};
        vecs[8] = '{1'b1, 3'd5, 32'h0000_0900, F3_BLTU, 32'd1,         32'd2,         32'h0000_0A00, 1'b1, 1'b0, 32'h0000_0A00};
        vecs[9] = '{1'b0, 3'd2, 32'h0000_0A00, 3'b011,  32'd5,         32'd9,         32'h0000_0B00, 1'b0, 1'b0, 32'h0000_0A04};

        rst = 1'b1; stall = 1'b0; id_enq = 1'b0; id_pred_taken = 1'b0; id_pht_index = '0;
        id_pc = '0; ex_valid = 1'b0; ex_funct3 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_target = '0;
        step();
        step();
        chk("rst_resolved",  32'(branch_resolved), 32'd0);
        chk("rst_mispred",   32'(mispredict),      32'd0);
        chk("rst_flush",     32'(flush),           32'd0);
        chk("rst_full",      32'(fifo_full),       32'd0);
        chk("rst_proto",     32'(protocol_err),    32'd0);
        chk("rst_redirect",  redirect_pc,          32'd0);
        chk("rst_stat_br",   stat_branches,        32'd0);
        chk("rst_stat_mp",   stat_mispredicts,     32'd0);
        rst = 1'b0;
        step();

        // One enqueue then one resolve per vector.
        for (int i = 0; i < 10; i++) begin
            drive_enq(vecs[i].pt, vecs[i].idx, vecs[i].pc);
            drive_ex(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].tgt,
                     vecs[i].e_taken, vecs[i].e_mp, vecs[i].idx, vecs[i].e_redir);
            if (vecs[i].e_mp) begin
                chk("vec_flush_c1", 32'(flush), 32'd1);
                step();
                chk("vec_flush_c2", 32'(flush), 32'd1);
                step();
                chk("vec_flush_end", 32'(flush), 32'd0);
            end else begin
                chk("vec_no_flush", 32'(flush), 32'd0);
                step();
                chk("vec_single_pulse", 32'(branch_resolved), 32'd0);
            end
        end

        // Mispredict with younger entries queued: they must be squashed, as must an enqueue during flush.
        drive_enq(1'b1, 3'd1, 32'h0000_0200);
        drive_enq(1'b0, 3'd2, 32'h0000_0204);
        drive_enq(1'b0, 3'd3, 32'h0000_0208);
        drive_ex(F3_BNE, 32'd5, 32'd5, 32'h0000_0300, 1'b0, 1'b1, 3'd1, 32'h0000_0204);
        chk("sq_flush_c1", 32'(flush), 32'd1);
        drive_enq(1'b1, 3'd7, 32'hDEAD_0000);
        chk("sq_flush_c2", 32'(flush), 32'd1);
        step();
        chk("sq_flush_end", 32'(flush), 32'd0);

        // Fill to full from a cleared FIFO.
        for (int k = 1; k <= 4; k++) begin
            drive_enq(1'b0, 3'(k), 32'h0000_1000 + 32'(16 * k));
            if (k == 3) chk("fill_not_full", 32'(fifo_full), 32'd0);
        end
        chk("fill_full", 32'(fifo_full), 32'd1);

        // Enqueue and dequeue together while full.
        id_enq = 1'b1; id_pred_taken = 1'b0; id_pht_index = 3'd5; id_pc = 32'h0000_1050;
        set_ex(3'b010, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 3'd1, 32'h0000_1014);
        step();
        id_enq = 1'b0; ex_valid = 1'b0;
        chk("enq_deq_full", 32'(fifo_full), 32'd1);

        // Enqueue alone while full must be dropped.
        drive_enq(1'b1, 3'd6, 32'h0000_1060);
        chk("drop_full", 32'(fifo_full), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            drive_ex(3'b010, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 3'(k), 32'h0000_1004 + 32'(16 * k));
        end
        chk("drain_not_full", 32'(fifo_full), 32'd0);

        // Orphan EX branch: FIFO is empty, so resolve with zero entry and flag the error.
        chk("proto_before", 32'(protocol_err), 32'd0);
        drive_ex(F3_BNE, 32'd3, 32'd3, 32'h0000_5000, 1'b0, 1'b0, 3'd0, 32'h0000_0004);
        chk("proto_set", 32'(protocol_err), 32'd1);
        step();
        step();
        chk("proto_sticky", 32'(protocol_err), 32'd1);

        // Stall freezes the FIFO and holds the MEM outputs.
        drive_enq(1'b1, 3'd3, 32'h0000_2000);
        stall = 1'b1; ex_valid = 1'b1; ex_funct3 = F3_BEQ; ex_rs1 = 32'd4; ex_rs2 = 32'd4;
        ex_target = 32'h0000_2100;
        step();
        chk("stall_no_resolve", 32'(branch_resolved), 32'd0);
        stall = 1'b0;
        set_ex(F3_BEQ, 32'd4, 32'd4, 32'h0000_2100, 1'b1, 1'b0, 3'd3, 32'h0000_2100);
        step();
        ex_valid = 1'b0; stall = 1'b1;
        step();
        chk("stall_hold_res", 32'(branch_resolved), 32'd1);
        chk("stall_hold_idx", 32'(pht_index_mem),   32'd3);
        stall = 1'b0;
        step();
        chk("stall_no_repeat", 32'(branch_resolved), 32'd0);

`ifdef BRANCH_STATS_EN
        chk("stat_branches",    stat_branches,    32'(n_br));
        chk("stat_mispredicts", stat_mispredicts, 32'(n_mp));
`else
        chk("stat_branches_off",    stat_branches,    32'd0);
        chk("stat_mispredicts_off", stat_mispredicts, 32'd0);
`endif

        // Reset in the middle of a flush.
        drive_enq(1'b1, 3'd2, 32'h0000_3000);
        drive_ex(F3_BNE, 32'd1, 32'd1, 32'h0000_3100, 1'b0, 1'b1, 3'd2, 32'h0000_3004);
        chk("rf_flush", 32'(flush), 32'd1);
        rst = 1'b1;
        step();
        chk("rf_flush_cleared", 32'(flush),           32'd0);
        chk("rf_proto_cleared", 32'(protocol_err),    32'd0);
        chk("rf_resolved",      32'(branch_resolved), 32'd0);
        chk("rf_stat_br",       stat_branches,        32'd0);
        rst = 1'b0;
        step();
        chk("rf_stays_idle", 32'(flush), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
